// File: rtl/matvec_stream_engine_if.sv
// Stream bundle for the matrix-vector engine: vector and matrix inputs, result output.
// Handshake: a beat transfers on a rising aclk edge only when tvalid and tready are both high.
// The source holds tdata/tlast stable while tvalid is high and tready is low.
interface matvec_stream_engine_if #(
    parameter int D_WIDTH   = 32,
    parameter int ACC_WIDTH = 64
);
    logic                 s_axis_vector_tvalid;
    logic [D_WIDTH-1:0]   s_axis_vector_tdata;
    logic                 s_axis_vector_tready;

    logic                 s_axis_matrix_tvalid;
    logic [D_WIDTH-1:0]   s_axis_matrix_tdata;
    logic                 s_axis_matrix_tlast;
    logic                 s_axis_matrix_tready;

    logic                 m_axis_result_tvalid;
    logic [ACC_WIDTH-1:0] m_axis_result_tdata;
    logic                 m_axis_result_tlast;
    logic                 m_axis_result_tready;

    // Stimulus/consumer side
    modport master (
        output s_axis_vector_tvalid, s_axis_vector_tdata,
        input  s_axis_vector_tready,
        output s_axis_matrix_tvalid, s_axis_matrix_tdata, s_axis_matrix_tlast,
        input  s_axis_matrix_tready,
        input  m_axis_result_tvalid, m_axis_result_tdata, m_axis_result_tlast,
        output m_axis_result_tready
    );

    // Engine side
    modport slave (
        input  s_axis_vector_tvalid, s_axis_vector_tdata,
        output s_axis_vector_tready,
        input  s_axis_matrix_tvalid, s_axis_matrix_tdata, s_axis_matrix_tlast,
        output s_axis_matrix_tready,
        output m_axis_result_tvalid, m_axis_result_tdata, m_axis_result_tlast,
        input  m_axis_result_tready
    );
endinterface

// File: rtl/matvec_stream_engine.sv
// Streaming matrix-vector multiplier. A vector of COLS signed words is loaded,
// then row-major matrix beats are multiply-accumulated against it; each finished
// row produces one ACC_WIDTH result word through a small FIFO.
module matvec_stream_engine #(
    parameter int D_WIDTH    = 32,
    parameter int ROWS       = 10,
    parameter int COLS       = 10,
    parameter int ACC_WIDTH  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    matvec_stream_engine_if.slave  axis,
    input  logic                   cfg_keep_vector,
    output logic                   reset_done,
    output logic                   err_tlast,
    output logic                   dbg_state
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int PRODW = 2 * D_WIDTH;

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

    typedef enum logic {
        LOAD_VEC = 1'b0,
        STREAM   = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic                         reset_done_q, reset_done_d;
    logic [CW-1:0]                col_q, col_d;
    logic [RW-1:0]                row_q, row_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [D_WIDTH-1:0]    v_q [COLS];
    logic signed [D_WIDTH-1:0]    v_d [COLS];
    logic [ACC_WIDTH-1:0]         mem_data_q [FIFO_DEPTH];
    logic [ACC_WIDTH-1:0]         mem_data_d [FIFO_DEPTH];
    logic                         mem_last_q [FIFO_DEPTH];
    logic                         mem_last_d [FIFO_DEPTH];
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]                count_q, count_d;
    logic                         err_q, err_d;

    logic                         vec_ready;
    logic                         mat_ready;
    logic                         vec_fire;
    logic                         mat_fire;
    logic                         end_col;
    logic                         end_row;
    logic                         end_frame;
    logic                         push;
    logic                         pop;
    logic                         res_valid;
    logic signed [PRODW-1:0]      a_ext;
    logic signed [PRODW-1:0]      b_ext;
    logic signed [PRODW-1:0]      prod;
    logic signed [ACC_WIDTH-1:0]  base;
    logic signed [ACC_WIDTH-1:0]  sum;

    // FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= LOAD_VEC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave LOAD_VEC after the last vector beat; leave STREAM
    // at end of frame unless the vector is to be reused
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_VEC: if (vec_fire && end_col) state_d = STREAM;
            STREAM:   if (end_frame && !cfg_keep_vector) state_d = LOAD_VEC;
            default:  state_d = LOAD_VEC;
        endcase
    end

    // FSM outputs: tready is gated until the reset-done flag is up; matrix beats
    // are refused while the FIFO is full so a push can never overflow it
    always_comb begin
        vec_ready = 1'b0;
        mat_ready = 1'b0;
        if (reset_done_q) begin
            case (state_q)
                LOAD_VEC: vec_ready = 1'b1;
                STREAM:   mat_ready = (count_q < CNT_FULL);
                default:  ;
            endcase
        end
    end

    // Datapath: counters, vector store, MAC, FIFO bookkeeping and tlast checking
    always_comb begin
        vec_fire  = axis.s_axis_vector_tvalid && vec_ready;
        mat_fire  = axis.s_axis_matrix_tvalid && mat_ready;
        end_col   = (col_q == COL_LAST);
        end_row   = (row_q == ROW_LAST);
        end_frame = mat_fire && end_col && end_row;

        a_ext = PRODW'($signed(axis.s_axis_matrix_tdata));
        b_ext = PRODW'(v_q[col_q]);
        prod  = a_ext * b_ext;
        base  = (col_q == '0) ? '0 : acc_q;
        sum   = base + ACC_WIDTH'(prod);

        push = mat_fire && end_col;
        pop  = res_valid && axis.m_axis_result_tready;

        reset_done_d = 1'b1;
        col_d        = col_q;
        row_d        = row_q;
        acc_d        = acc_q;
        v_d          = v_q;
        mem_data_d   = mem_data_q;
        mem_last_d   = mem_last_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_d        = err_q;

        if (vec_fire) begin
            v_d[col_q] = axis.s_axis_vector_tdata;
        end
        if (vec_fire || mat_fire) begin
            col_d = end_col ? '0 : col_q + 1'b1;
        end
        if (mat_fire) begin
            acc_d = sum;
            if (end_col) begin
                row_d = end_row ? '0 : row_q + 1'b1;
            end
            if (axis.s_axis_matrix_tlast != (end_col && end_row)) begin
                err_d = 1'b1;
            end
        end
        if (push) begin
            mem_data_d[wr_ptr_q] = sum;
            mem_last_d[wr_ptr_q] = end_row;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Datapath registers, all cleared by reset so a reset mid-frame drops everything
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            reset_done_q <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            acc_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < COLS; i++) begin
                v_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_last_q[i] <= 1'b0;
            end
        end else begin
            reset_done_q <= reset_done_d;
            col_q        <= col_d;
            row_q        <= row_d;
            acc_q        <= acc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
            v_q          <= v_d;
            mem_data_q   <= mem_data_d;
            mem_last_q   <= mem_last_d;
        end
    end

    // Result stream driven from the FIFO head; forced to zero when empty
    always_comb begin
        res_valid = (count_q != '0);
    end

    assign axis.s_axis_vector_tready = vec_ready;
    assign axis.s_axis_matrix_tready = mat_ready;
    assign axis.m_axis_result_tvalid = res_valid;
    assign axis.m_axis_result_tdata  = res_valid ? mem_data_q[rd_ptr_q] : '0;
    assign axis.m_axis_result_tlast  = res_valid ? mem_last_q[rd_ptr_q] : 1'b0;
    assign reset_done                = reset_done_q;
    assign err_tlast                 = err_q;
    assign dbg_state                 = state_q;

    // The matrix tready gating must keep pushes away from a full FIFO
    push_never_full: assert property (@(posedge aclk) disable iff (!aresetn)
        !(push && !pop && count_q == CNT_FULL));

endmodule
